sseg_display_arbiter: RTL

Shares the four-digit seven-segment display between up to four on-chip requesters (program counter, register probe, memory-bus probe, debug/status word). Each requester raises a request with a 16-bit value. The arbiter grants the display round-robin for a fixed minimum dwell time and drives the winning value onto the 16-bit `data` input of the seven-segment scan driver. It sits between the PUnC datapath/debug taps and the display driver at FPGA top level.

---
 rtl/sseg_display_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner of the four-digit seven-segment display: grants one of four
// requesters for a fixed dwell and forwards its live 16-bit value to the scan driver.
module sseg_display_arbiter #(
    parameter int unsigned DWELL_CYCLES = 32'd50000000
) (
    input  logic        i_sysclk,
    input  logic        i_rst,
    input  logic [3:0]  i_req,
    input  logic [63:0] i_src_data,
    input  logic        i_freeze,
    output logic [15:0] o_disp_data,
    output logic [3:0]  o_grant,
    output logic        o_active,
    output logic [3:0]  o_done
);

    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_SHOW   = 1'b1;
    localparam logic [31:0] LAST_CNT = 32'(DWELL_CYCLES - 32'd1);

    // Returns {found, index}: first set request searching upward from last+1 with wrap.
    function automatic logic [2:0] f_rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 0; k < 4; k++) begin
            idx = last + 2'(k + 1);
            if (!pick[2] && req[idx]) begin
                pick = {1'b1, idx};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    logic [0:0]  r_state;
    logic [31:0] r_cnt;
    logic [1:0]  r_last;
    logic [1:0]  r_owner;
    logic [3:0]  r_grant;
    logic        r_active;
    logic [3:0]  r_done;
    logic [15:0] r_disp;

    logic [2:0]  w_pick;
    logic        w_rearb;
    logic [0:0]  w_nstate;
    logic [31:0] w_ncnt;
    logic [1:0]  w_nlast;
    logic [1:0]  w_nowner;
    logic [3:0]  w_ngrant;
    logic [3:0]  w_ndone;
    logic [15:0] w_ndisp;

    assign w_pick = f_rr_pick(i_req, r_last);

    // Next-state logic: dwell tracking, done pulse and (re)arbitration.
    always_comb begin
        w_rearb  = 1'b0;
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_nlast  = r_last;
        w_nowner = r_owner;
        w_ngrant = r_grant;
        w_ndone  = 4'b0000;
        w_ndisp  = r_disp;
        case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_rearb = 1'b1;
                end else begin
                    w_rearb = 1'b0;
                end
            end
            S_SHOW: begin
                if (!i_req[r_owner]) begin
                    w_rearb = 1'b1;
                end else if (!i_freeze && (r_cnt == LAST_CNT)) begin
                    w_rearb           = 1'b1;
                    w_ndone[r_owner]  = 1'b1;
                end else begin
                    w_ndisp = i_src_data[16*r_owner +: 16];
                    if (!i_freeze) begin
                        w_ncnt = r_cnt + 32'd1;
                    end else begin
                        w_ncnt = r_cnt;
                    end
                end
            end
            default: begin
                w_nstate = S_IDLE;
                w_ngrant = 4'b0000;
                w_ncnt   = 32'd0;
            end
        endcase
        // A finished or released grant hands over in the same cycle; no idle bubble.
        if (w_rearb) begin
            if (w_pick[2]) begin
                w_nstate = S_SHOW;
                w_nowner = w_pick[1:0];
                w_nlast  = w_pick[1:0];
                w_ngrant = 4'b0001 << w_pick[1:0];
                w_ncnt   = 32'd0;
                w_ndisp  = i_src_data[16*w_pick[1:0] +: 16];
            end else begin
                w_nstate = S_IDLE;
                w_ngrant = 4'b0000;
                w_ncnt   = 32'd0;
            end
        end else begin
            w_nstate = w_nstate;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_sysclk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 32'd0;
            r_last   <= 2'd3;
            r_owner  <= 2'd0;
            r_grant  <= 4'b0000;
            r_active <= 1'b0;
            r_done   <= 4'b0000;
            r_disp   <= 16'h0000;
        end else begin
            r_state  <= w_nstate;
            r_cnt    <= w_ncnt;
            r_last   <= w_nlast;
            r_owner  <= w_nowner;
            r_grant  <= w_ngrant;
            r_active <= |w_ngrant;
            r_done   <= w_ndone;
            r_disp   <= w_ndisp;
        end
    end

    assign o_disp_data = r_disp;
    assign o_grant     = r_grant;
    assign o_active    = r_active;
    assign o_done      = r_done;

endmodule
